// File: rtl/sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_like_arbiter
// Purpose  : Shares one sram-like master port between the instruction-fetch
//            requester (inst_*) and the load/store requester (data_*).
//            Address phases are arbitrated, and the id of every accepted
//            transaction is queued in an order FIFO. Each in-order response
//            is steered back to the requester that issued it.
// Ports    : clk, reset                    - clock, synchronous active-high reset
//            inst_* / data_*               - requester address/response channels
//            m_*                           - shared downstream master channel
//            outstanding                   - order FIFO occupancy
//            err                           - sticky: response seen with empty FIFO
// Options  : ARB_RR_EN - when defined, free-state arbitration is round-robin
//            (inst wins the first contention); otherwise data has fixed
//            priority over inst.
// Revision : 1.0 - initial release
// ============================================================================
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int CNT_W       = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inst_req,
    input  logic             inst_wr,
    input  logic [1:0]       inst_size,
    input  logic [3:0]       inst_wstrb,
    input  logic [31:0]      inst_addr,
    input  logic [31:0]      inst_wdata,
    output logic             inst_addr_ok,
    output logic             inst_data_ok,
    output logic [31:0]      inst_rdata,
    input  logic             data_req,
    input  logic             data_wr,
    input  logic [1:0]       data_size,
    input  logic [3:0]       data_wstrb,
    input  logic [31:0]      data_addr,
    input  logic [31:0]      data_wdata,
    output logic             data_addr_ok,
    output logic             data_data_ok,
    output logic [31:0]      data_rdata,
    output logic             m_req,
    output logic             m_wr,
    output logic [1:0]       m_size,
    output logic [3:0]       m_wstrb,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_wdata,
    input  logic             m_addr_ok,
    input  logic             m_data_ok,
    input  logic [31:0]      m_rdata,
    output logic [CNT_W-1:0] outstanding,
    output logic             err
);

    localparam int                 c_PTR_W     = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST  = c_PTR_W'(OUTSTANDING - 1);
    localparam logic [CNT_W-1:0]   c_CNT_MAX   = CNT_W'(OUTSTANDING);
    localparam logic [0:0]         c_ST_FREE   = 1'b0;
    localparam logic [0:0]         c_ST_LOCKED = 1'b1;

    // Requester ids: 0 = inst, 1 = data.
    logic [0:0]             r_state;
    logic [0:0]             w_state_nxt;
    logic                   r_lock_id;
    logic                   w_lock_id_nxt;
    logic                   w_arb_id;
    logic                   w_grant_id;
    logic                   w_sel_req;
    logic                   w_not_full;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_head_id;
    logic [OUTSTANDING-1:0] r_fifo;
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]       r_count;
    logic                   r_err;

    // ------------------------------------------------------------------
    // Free-state arbitration
    // ------------------------------------------------------------------
`ifdef ARB_RR_EN
    logic r_last_id;

    // On contention the requester that did not win last time gets the slot.
    always_comb begin
        if (inst_req && data_req) begin
            w_arb_id = ~r_last_id;
        end else begin
            w_arb_id = data_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_id <= 1'b1;
        end else if (w_push) begin
            r_last_id <= w_grant_id;
        end
    end
`else
    assign w_arb_id = data_req;
`endif

    // While locked, the stalled requester keeps the port so its address
    // phase cannot be replaced by the other requester mid-handshake.
    assign w_grant_id = (r_state == c_ST_LOCKED) ? r_lock_id : w_arb_id;
    assign w_sel_req  = w_grant_id ? data_req : inst_req;
    assign w_not_full = (r_count < c_CNT_MAX);

    assign m_req   = w_sel_req && w_not_full;
    assign m_wr    = w_grant_id ? data_wr    : inst_wr;
    assign m_size  = w_grant_id ? data_size  : inst_size;
    assign m_wstrb = w_grant_id ? data_wstrb : inst_wstrb;
    assign m_addr  = w_grant_id ? data_addr  : inst_addr;
    assign m_wdata = w_grant_id ? data_wdata : inst_wdata;

    assign w_push       = m_req && m_addr_ok;
    assign inst_addr_ok = w_push && !w_grant_id;
    assign data_addr_ok = w_push &&  w_grant_id;

    // ------------------------------------------------------------------
    // Response steering
    // ------------------------------------------------------------------
    assign w_head_id    = r_fifo[r_rd_ptr];
    assign w_pop        = m_data_ok && (r_count != '0);
    assign inst_data_ok = w_pop && !w_head_id;
    assign data_data_ok = w_pop &&  w_head_id;
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;

    assign outstanding = r_count;
    assign err         = r_err;

    // ------------------------------------------------------------------
    // Grant lock FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_lock_id_nxt = r_lock_id;
        if (r_state == c_ST_FREE) begin
            if (m_req && !m_addr_ok) begin
                w_state_nxt   = c_ST_LOCKED;
                w_lock_id_nxt = w_arb_id;
            end
        end else begin
            if (m_addr_ok) begin
                w_state_nxt = c_ST_FREE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_ST_FREE;
            r_lock_id <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_lock_id <= w_lock_id_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Order FIFO. The full check uses the registered count, so a pop in
    // the same cycle only frees the slot for the following cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fifo   <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_grant_id;
                r_wr_ptr         <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (m_data_ok && (r_count == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_like_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_like_arbiter
// Purpose  : Self-checking bench for sram_like_arbiter. Stimulus pushes the
//            expected response (requester id, read data) into a queue when an
//            address phase is issued; a monitor pops and compares whenever
//            the DUT raises inst_data_ok or data_data_ok.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_like_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr;
    logic [1:0]  inst_size;
    logic [3:0]  inst_wstrb;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic [2:0]  outstanding;
    logic        err;

`ifdef ARB_RR_EN
    localparam bit c_FIRST = 1'b0;
`else
    localparam bit c_FIRST = 1'b1;
`endif

    sram_like_arbiter #(.OUTSTANDING(2), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_wstrb(m_wstrb),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_addr_ok(m_addr_ok),
        .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .outstanding(outstanding), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    exp_t r_exp;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (inst_data_ok || data_data_ok) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
            end else begin
                r_exp = exp_q.pop_front();
                chk("resp_target", {30'b0, inst_data_ok, data_data_ok},
                    r_exp.id ? 32'h1 : 32'h2);
                chk("resp_rdata", r_exp.id ? data_rdata : inst_rdata, r_exp.rdata);
            end
        end
    end

    // One cycle: drive after the rising edge, return at the falling edge
    // where combinational outputs are sampled.
    task automatic cyc(input bit ir, input logic [31:0] ia,
                       input bit dr, input bit dw, input logic [31:0] da,
                       input bit mao, input bit mdo, input logic [31:0] mr);
        @(posedge clk);
        #1;
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wr    = dw;
        data_addr  = da;
        data_wstrb = dw ? 4'hF : 4'h0;
        m_addr_ok  = mao;
        m_data_ok  = mdo;
        m_rdata    = mr;
        @(negedge clk);
    endtask

    task automatic idle();
        cyc(0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    initial begin
        reset      = 1'b1;
        inst_req   = 0; inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'h0;
        inst_addr  = 0; inst_wdata = 0;
        data_req   = 0; data_wr = 0; data_size = 2'd2; data_wstrb = 4'h0;
        data_addr  = 0; data_wdata = 32'hCAFE0000;
        m_addr_ok  = 0; m_data_ok = 0; m_rdata = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_m_req", m_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_data_oks", {inst_data_ok, data_data_ok}, 0);
        chk("rst_outstanding", outstanding, 0);
        chk("rst_err", err, 0);

        // Contention right after reset
        cyc(1, 32'h1c000004, 1, 1, 32'h1c010000, 1, 0, 32'h0);
        chk("cont_inst_aok", inst_addr_ok, c_FIRST == 1'b0);
        chk("cont_data_aok", data_addr_ok, c_FIRST == 1'b1);
        chk("cont_m_addr", m_addr, c_FIRST ? 32'h1c010000 : 32'h1c000004);
        chk("cont_m_wr", m_wr, c_FIRST);
        chk("cont_m_wstrb", m_wstrb, c_FIRST ? 32'hF : 32'h0);
        exp_q.push_back('{c_FIRST, 32'h11110001});
        cyc(c_FIRST, 32'h1c000004, !c_FIRST, 1, 32'h1c010000, 1, 0, 32'h0);
        chk("cont_second_aok", c_FIRST ? inst_addr_ok : data_addr_ok, 1);
        chk("cont_out1", outstanding, 1);
        exp_q.push_back('{!c_FIRST, 32'h22220002});
        idle();
        chk("cont_out2", outstanding, 2);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h11110001);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h22220002);
        idle();
        chk("cont_out0", outstanding, 0);

        // Single instruction read
        cyc(1, 32'h1c000000, 0, 0, 0, 1, 0, 32'h0);
        chk("single_m_req", m_req, 1);
        chk("single_m_addr", m_addr, 32'h1c000000);
        chk("single_inst_aok", inst_addr_ok, 1);
        exp_q.push_back('{1'b0, 32'h02c00421});
        idle();
        chk("single_out1", outstanding, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h02c00421);
        idle();
        chk("single_out0", outstanding, 0);

        // Lock hold
        cyc(0, 0, 1, 0, 32'h1c010000, 0, 0, 32'h0);
        chk("lock_m_req", m_req, 1);
        chk("lock_data_aok0", data_addr_ok, 0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 32'h1c000008, 1, 0, 32'h1c010000, 0, 0, 32'h0);
            chk("lock_m_addr", m_addr, 32'h1c010000);
            chk("lock_inst_aok", inst_addr_ok, 0);
        end
        cyc(1, 32'h1c000008, 1, 0, 32'h1c010000, 1, 0, 32'h0);
        chk("lock_accept_addr", m_addr, 32'h1c010000);
        chk("lock_data_aok", data_addr_ok, 1);
        chk("lock_inst_aok_acc", inst_addr_ok, 0);
        exp_q.push_back('{1'b1, 32'h33330003});
        cyc(1, 32'h1c000008, 0, 0, 0, 1, 0, 32'h0);
        chk("lock_inst_after", inst_addr_ok, 1);
        exp_q.push_back('{1'b0, 32'h44440004});

        // Full: pop in cycle N must not unblock the push until N+1
        cyc(1, 32'h1c00000c, 0, 0, 0, 1, 1, 32'h33330003);
        chk("full_m_req", m_req, 0);
        chk("full_inst_aok", inst_addr_ok, 0);
        chk("full_out", outstanding, 2);
        cyc(1, 32'h1c00000c, 0, 0, 0, 1, 1, 32'h44440004);
        chk("full_next_m_req", m_req, 1);
        chk("full_next_aok", inst_addr_ok, 1);
        chk("full_next_out", outstanding, 1);
        exp_q.push_back('{1'b0, 32'h55550005});
        idle();
        chk("pushpop_out", outstanding, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h55550005);
        idle();
        chk("full_out0", outstanding, 0);

        // Ordering
        cyc(1, 32'h1c000010, 0, 0, 0, 1, 0, 32'h0);
        exp_q.push_back('{1'b0, 32'hAAAA0000});
        cyc(0, 0, 1, 0, 32'h1c010004, 1, 0, 32'h0);
        chk("order_data_aok", data_addr_ok, 1);
        exp_q.push_back('{1'b1, 32'h5555FFFF});
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hAAAA0000);
        cyc(0, 0, 0, 0, 0, 0, 1, 32'h5555FFFF);
        idle();
        chk("order_out0", outstanding, 0);

        // Reset mid-flight: the pending response must be dropped
        cyc(1, 32'h1c000014, 0, 0, 0, 1, 0, 32'h0);
        idle();
        chk("mid_out1", outstanding, 1);
        chk("mid_err0", err, 0);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 1, 32'hDEAD0000);
        chk("mid_no_data_ok", {inst_data_ok, data_data_ok}, 0);
        idle();
        chk("mid_err1", err, 1);
        chk("mid_out0", outstanding, 0);
        idle();
        chk("mid_err_sticky", err, 1);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one sram-like master port between the instruction-fetch requester (inst_*) and the load/store requester (data_*).
- Sits between the IF/MEM pipeline stages and the downstream memory bridge.
- Arbitrates address-phase requests and tracks outstanding transactions in an order FIFO.
- Returns each in-order response (m_data_ok) to the requester that issued it.

Parameters:
- OUTSTANDING, 2: maximum accepted-but-unanswered transactions (order FIFO depth), 1..4.
- CNT_W, 3: width of outstanding counter; must hold 0..OUTSTANDING.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- inst_req  in  1  instruction request valid
- inst_wr  in  1  write flag (tied 0 by IF, still forwarded)
- inst_size  in  2  0=byte, 1=half, 2=word
- inst_wstrb  in  4  byte strobes
- inst_addr  in  32  address
- inst_wdata  in  32  write data
- inst_addr_ok  out  1  inst address phase accepted this cycle
- inst_data_ok  out  1  inst response this cycle
- inst_rdata  out  32  inst read data
- data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata  in  1/1/2/4/32/32  same meanings for data requester
- data_addr_ok  out  1  data address phase accepted
- data_data_ok  out  1  data response
- data_rdata  out  32  data read data
- m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/1/2/4/32/32  master request fields, muxed from granted requester
- m_addr_ok  in  1  downstream accepted address phase
- m_data_ok  in  1  downstream response (in order)
- m_rdata  in  32  downstream read data
- outstanding  out  CNT_W  current FIFO occupancy
- err  out  1  sticky: m_data_ok seen with FIFO empty

Behaviour:
- Reset: clock clk; reset is synchronous and active-high. Reset clears FIFO, count, lock and err.
  - Outputs after reset: m_req=0, all *_addr_ok=0, all *_data_ok=0, outstanding=0, err=0.
  - Reset mid-transaction drops all tracking; responses arriving later with an empty FIFO set err.
- Grant states:
  - FREE: grant chosen combinationally from the current inst_req/data_req.
  - LOCKED: grant held in register lock_id.
- Arbitration in FREE: data has fixed priority over inst.
- FREE->LOCKED when m_req=1 && m_addr_ok=0; lock_id is set to the current grant.
- LOCKED->FREE on the cycle m_addr_ok=1.
- While LOCKED, m_* fields are driven from the locked requester regardless of the other requester's req. The requester must hold its fields stable (sram-like rule).
- m_req = (selected requester's req) && (outstanding < OUTSTANDING).
- When full, m_req=0 and no addr_ok is issued. A pop in the same cycle does not unblock the push; it frees the slot for the next cycle.
- Address handshake: m_req && m_addr_ok → granted requester's addr_ok=1 (same cycle, combinational), and its id (0=inst, 1=data) is pushed into the FIFO.
- Response: m_data_ok=1 with FIFO non-empty → head id selects inst_data_ok or data_data_ok; both rdata outputs carry m_rdata; FIFO pops.
- m_data_ok=1 with FIFO empty → err<=1, no requester data_ok.
- Simultaneous push and pop → count unchanged, FIFO pointers both advance.
- Pointers wrap modulo OUTSTANDING.
- Zero-latency path: addr_ok and data_ok may occur in the same cycle for different transactions.

Optional Feature:
- ARB_RR_EN defined: FREE-state arbitration is round-robin.
  - Register last_id updates on each accepted address phase.
  - On contention, the requester not equal to last_id wins; reset value last_id=1, so inst wins first contention.
- ARB_RR_EN undefined: fixed data-over-inst priority; no last_id register.

Test Plan:
- Single inst read: inst_req=1, addr=0x1c000000; m_addr_ok=1 same cycle, m_data_ok two cycles later with rdata=0x02c00421 → inst_addr_ok=1 cycle 0, inst_data_ok=1 with inst_rdata=0x02c00421, outstanding 1→0.
- Contention: both req in same cycle, data addr=0x1c010000 wr=1 wstrb=0xF → data granted first (fixed) or inst first (ARB_RR_EN), the other requester on the next accept.
- Lock hold: data_req=1, m_addr_ok=0 for 3 cycles, inst_req rises in cycle 1 → m_addr stays 0x1c010000 until accepted; inst_addr_ok stays 0.
- Full: OUTSTANDING=2, two accepted, no responses → third request sees m_req=0. m_data_ok in cycle N → accept allowed in cycle N+1, not N.
- Ordering: accept inst then data, responses 0xAAAA0000 then 0x5555FFFF → inst_data_ok with 0xAAAA0000 first, data_data_ok with 0x5555FFFF second.
- Reset mid-flight: one outstanding, assert reset, then m_data_ok=1 → no data_ok to either requester, err=1.
